// File: rtl/dm_responder.sv
// dm_responder: handshaked word-addressed data-memory responder.
// A request is accepted in IDLE and held internally. The responder then waits
// WAIT_CYCLES states in BUSY, commits the read or write, and pulses ready for
// one cycle in RESP. Memory words are flops so that reset can clear them.
module dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [3:0]  be_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];

  // Transaction fields seen at the commit edge. They come straight from the
  // ports for a zero-wait accept, and from the latched copy otherwise.
  logic                  commit;
  logic                  c_we;
  logic [3:0]            c_be;
  logic [29:0]           c_waddr;
  logic [31:0]           c_wdata;
  logic                  c_oor;
  logic [ADDR_WIDTH-1:0] c_idx;

  // Byte-address bits [1:0] carry no meaning for a word-addressed RAM.
  logic unused_bits;
  assign unused_bits = ^addr[1:0];

  // Merge new write data into the old word lane by lane.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Select the commit-edge transaction and decide whether this edge commits.
  always_comb begin
    commit  = 1'b0;
    c_we    = we_q;
    c_be    = be_q;
    c_waddr = waddr_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_we    = we;
      c_be    = be;
      c_waddr = addr[31:2];
      c_wdata = wdata;
      commit  = req && (WAIT_CYCLES == 0);
    end else if (state == BUSY) begin
      commit  = (cnt == 4'd1);
    end
    c_oor = (c_waddr >> ADDR_WIDTH) != 30'd0;
    c_idx = c_waddr[ADDR_WIDTH-1:0];
  end

  // Control FSM, registered outputs and memory array with full clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      rdata   <= 32'd0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      waddr_q <= 30'd0;
      wdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            be_q    <= be;
            waddr_q <= addr[31:2];
            wdata_q <= wdata;
            cnt     <= WAIT_LD;
            state   <= (WAIT_CYCLES == 0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // The edge that enters RESP performs the access and raises ready.
      if (commit) begin
        ready <= 1'b1;
        if (c_oor) begin
          err <= 1'b1;
        end else if (c_we) begin
          mem[c_idx] <= merge_bytes(mem[c_idx], c_wdata, c_be);
        end else begin
          rdata <= mem[c_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed vectors for dm_responder.
// The first instance uses WAIT_CYCLES=2 and the second WAIT_CYCLES=0.
// Both instances share the clock and the reset.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        ready, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
  );

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .be(be0), .addr(addr0),
    .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with latency check.
  task automatic run_txn(input string name, input logic twe, input logic [3:0] tbe,
                         input logic [31:0] taddr, input logic [31:0] twd,
                         input logic [31:0] exp_rd, input logic exp_err);
    int  n;
    bit  got;
    @(negedge clk);
    req = 1'b1; we = twe; be = tbe; addr = taddr; wdata = twd;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) got = 1;
    end
    chk({name, " latency"}, n, 3);
    chk({name, " rdata"}, rdata, exp_rd);
    chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    req = 1'b0;
    @(negedge clk);
    chk({name, " pulse_end"}, {31'd0, ready}, 32'd0);
  endtask

  vec_t vecs [13];

  initial begin
    bit seen;
    vecs[0]  = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h0000_0020, 32'hDEADBEEF,  32'h0,         1'b0};
    vecs[2]  = '{1'b1, 4'b0010, 32'h0000_0020, 32'h0000AB00,  32'h0,         1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0000_0020, 32'h0,         32'hDEADABEF,  1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 32'h0000_0020, 32'h11223344,  32'h0,         1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0000_0020, 32'h0,         32'hDEADABEF,  1'b0};
    vecs[8]  = '{1'b1, 4'b1001, 32'h0000_0024, 32'hA5A5A5A5,  32'h0,         1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0000_0024, 32'h0,         32'hA50000A5,  1'b0};
    vecs[10] = '{1'b1, 4'b1111, 32'h0000_1000, 32'hFFFFFFFF,  32'h0,         1'b1};
    vecs[11] = '{1'b0, 4'b0000, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{1'b0, 4'b0000, 32'h0000_0023, 32'h0,         32'hDEADABEF,  1'b0};

    reset = 1'b0;
    req = 0; we = 0; be = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    reset = 1'b1;

    // Zero-wait instance: a single write has a latency of one cycle.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h0; wdata0 = 32'h0BADF00D;
    @(negedge clk);
    chk("w0 write ready", {31'd0, ready0}, 32'd1);
    chk("w0 write rdata", rdata0, 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk("w0 idle", {31'd0, ready0}, 32'd0);

    // Zero-wait instance: req held for 6 cycles. ready must alternate.
    // Accepted reads alternate between word 0 and word 1.
    for (int k = 0; k < 6; k++) begin
      req0  = 1'b1;
      addr0 = ((k >> 1) & 1) ? 32'h4 : 32'h0;
      @(negedge clk);
      chk($sformatf("w0 stream ready[%0d]", k), {31'd0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0)
        chk($sformatf("w0 stream rdata[%0d]", k), rdata0, (k == 2) ? 32'h0 : 32'h0BADF00D);
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("w0 stream end", {31'd0, ready0}, 32'd0);

    // Table of single transactions on the WAIT_CYCLES=2 instance.
    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].be, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset during BUSY aborts the write, gives no ready and clears memory.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h12345678;
    @(negedge clk);
    reset = 1'b0; req = 1'b0; we = 1'b0;
    #1 chk("abort ready in reset", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1;
    end
    chk("abort no ready", {31'd0, seen}, 32'd0);
    run_txn("abort read 0x40", 1'b0, 4'h0, 32'h40, 32'h0, 32'h0, 1'b0);
    run_txn("abort read 0x20", 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b0);

    // Changes to addr and wdata during BUSY must be ignored.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    addr = 32'h44; wdata = 32'h55555555;
    @(negedge clk);
    @(negedge clk);
    chk("hold write ready", {31'd0, ready}, 32'd1);
    req = 1'b0; we = 1'b0;
    run_txn("hold read 0x40", 1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    run_txn("hold read 0x44", 1'b0, 4'h0, 32'h44, 32'h0, 32'h0, 1'b0);

    // Reset asserted during RESP drops ready at once.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40;
    repeat (3) @(negedge clk);
    chk("resp ready before reset", {31'd0, ready}, 32'd1);
    reset = 1'b0; req = 1'b0;
    #1 chk("resp ready after reset", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the pipeline's data-memory port. It replaces the single-cycle data memory with a handshaked word-addressed RAM that inserts a configurable number of wait states. The M stage issues `req` and holds the transaction stable. The hazard unit keeps the pipeline stalled until `ready` pulses. Reads return a full word; writes honour per-byte enables for sw/sh/sb.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; capacity is 2^ADDR_WIDTH words (4 KiB at default).
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and response; legal range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears state, outputs and memory contents.
- `req`  in  1  transaction request from the M stage.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `be`  in  4  byte enables, bit i selects byte lane i (`wdata[8i+7:8i]`); ignored on reads.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  write data.
- `ready`  out  1  one-cycle pulse marking transaction completion.
- `rdata`  out  32  read data, valid while `ready`=1.
- `err`  out  1  out-of-range flag, valid while `ready`=1.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - With `req`=1, latch `we`, `be`, `addr`, `wdata` and load the wait counter with WAIT_CYCLES.
  - Go to BUSY if WAIT_CYCLES>0; otherwise go directly to RESP.
- BUSY:
  - Decrement the counter each cycle.
  - On the edge where the counter goes from 1 to 0, go to RESP.
  - Inputs are not re-sampled; changes to `req` or `addr` in BUSY have no effect.
- Commit edge: the edge that enters RESP.
  - Read: `rdata` is registered from mem[`addr`[ADDR_WIDTH+1:2]].
  - Write: lanes with `be[i]`=1 are updated and other lanes are preserved. `rdata` is registered as 0.
- RESP:
  - `ready`=1 for exactly one cycle.
  - `req` is ignored in this cycle.
  - Next state is always IDLE.
- Out of range: `addr`[31:ADDR_WIDTH+2] ≠ 0.
  - No write occurs.
  - `rdata`=0 and `err`=1 during RESP.
- `err` is 0 whenever `ready`=0.
- `be`=4'b0000 on a write completes normally with no memory change.
- Requester rule: in the cycle after `ready`, `req` is either 0 or a new transaction. A still-asserted `req` in IDLE is always a new transaction.

## Timing
- Reset values: state=IDLE, `ready`=0, `rdata`=0, `err`=0, wait counter=0, every memory word=0.
- Latency: `ready` rises WAIT_CYCLES+1 cycles after the first IDLE cycle with `req`=1 (1 cycle when WAIT_CYCLES=0).
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles, because the IDLE acceptance cycle is mandatory after RESP.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-transaction (BUSY):
  - The transaction is aborted, with no write and no `ready` pulse.
  - Memory is zeroed.
  - After reset deassertion the block resumes in IDLE.
- Reset asserted during RESP: `ready` drops immediately (asynchronous).
- Write followed by a read to the same address: the read returns the new data, because the write committed before RESP.

## Test plan
- Reset, then read addr 0x0000_0010 with WAIT_CYCLES=2 -> `ready` pulses 3 cycles after `req`, `rdata`=0, `err`=0.
- Write 0xDEADBEEF, `be`=4'b1111, to 0x20; then write 0x0000_AB00, `be`=4'b0010, to 0x20; then read 0x20 -> `rdata`=0xDEADABEF.
- Read 0x0000_1000 with ADDR_WIDTH=10 -> `ready` pulse with `err`=1, `rdata`=0; a follow-up read of 0x0 is unchanged.
- WAIT_CYCLES=0, `req` held high for 6 cycles with alternating reads -> `ready` every 2nd cycle, never on consecutive cycles.
- Write 0x12345678 to 0x40, then assert `reset` low for one cycle while in BUSY -> no `ready`; a subsequent read of 0x40 returns 0.
- Change `addr` from 0x40 to 0x44 during BUSY of a write -> only word 0x40 is modified.
